// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : lcd_cmd_sequencer
//  Purpose  : HD44780-style LCD write sequencer. Paced by the 4 us timer tick,
//             it waits out the power-up delay, plays the fixed init sequence
//             (38,38,38,0C,01,06), then accepts command/data bytes over a
//             valid/ready handshake and drives RS/RW/E/DB. It owns the timer
//             through EnableCount/DisableCount.
//  Ports    : clock         system clock
//             rst           asynchronous reset, active-low
//             TimerTick     1-clock tick from the timer while enabled
//             EnableCount   timer run enable (high throughout timed phases)
//             DisableCount  1-clock pulse restarting the timer phase
//             cmd_valid     upstream byte available
//             cmd_rs        0 = instruction, 1 = data
//             cmd_data      byte to write
//             cmd_ready     sequencer can accept a byte
//             init_done     init sequence complete (sticky until reset)
//             lcd_rs        LCD register select
//             lcd_rw        LCD read/write, always 0 (write-only)
//             lcd_e         LCD enable strobe
//             lcd_data      LCD data bus
//  Revision : 1.0  initial release
// ============================================================================
module lcd_cmd_sequencer #(
  parameter int TICKS_POWERUP = 3750,
  parameter int TICKS_E_HIGH  = 1,
  parameter int TICKS_CMD     = 10,
  parameter int TICKS_CLEAR   = 410,
  parameter int CNT_W         = 12
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       TimerTick,
  output logic       EnableCount,
  output logic       DisableCount,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    S_PWR   = 3'd0,
    S_LOAD  = 3'd1,
    S_IDLE  = 3'd2,
    S_SETUP = 3'd3,
    S_EHI   = 3'd4,
    S_WAIT  = 3'd5
  } state_t;

  // Terminal counts are stored as N-1 so the phase ends on the Nth tick.
  localparam logic [CNT_W-1:0] c_pwr_last   = CNT_W'(TICKS_POWERUP - 1);
  localparam logic [CNT_W-1:0] c_ehi_last   = CNT_W'(TICKS_E_HIGH - 1);
  localparam logic [CNT_W-1:0] c_cmd_last   = CNT_W'(TICKS_CMD - 1);
  localparam logic [CNT_W-1:0] c_clr_last   = CNT_W'(TICKS_CLEAR - 1);
  localparam logic [2:0]       c_last_idx   = 3'd5;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_idx;

  logic [7:0]        w_rom;
  logic              w_is_clear;
  logic [CNT_W-1:0]  w_limit;
  logic              w_done;

  assign lcd_rw = 1'b0;

  // Init sequence: function set x3, display on, clear, entry mode.
  always_comb begin
    w_rom = 8'h38;
    case (r_idx)
      3'd3:    w_rom = 8'h0C;
      3'd4:    w_rom = 8'h01;
      3'd5:    w_rom = 8'h06;
      default: w_rom = 8'h38;
    endcase
  end

  // Clear display / return home (01..03) need the long execution delay.
  // The bus still holds the byte just strobed, so decode straight from it.
  assign w_is_clear = !lcd_rs &&
                      ((lcd_data == 8'h01) || (lcd_data == 8'h02) || (lcd_data == 8'h03));

  always_comb begin
    w_limit = '0;
    case (r_state)
      S_PWR:   w_limit = c_pwr_last;
      S_EHI:   w_limit = c_ehi_last;
      S_WAIT:  w_limit = w_is_clear ? c_clr_last : c_cmd_last;
      default: w_limit = '0;
    endcase
  end

  assign w_done = TimerTick && (r_cnt == w_limit);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state      <= S_PWR;
      r_cnt        <= '0;
      r_idx        <= '0;
      EnableCount  <= 1'b0;
      DisableCount <= 1'b0;
      cmd_ready    <= 1'b0;
      init_done    <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_e        <= 1'b0;
      lcd_data     <= 8'h00;
    end else begin
      DisableCount <= 1'b0;
      case (r_state)
        S_PWR: begin
          // Reset leaves the timer off; the first clock out of reset
          // starts the power-up phase so the restart pulse is visible.
          if (!EnableCount) begin
            EnableCount  <= 1'b1;
            DisableCount <= 1'b1;
            r_cnt        <= '0;
          end else if (TimerTick) begin
            if (w_done) begin
              EnableCount <= 1'b0;
              r_state     <= S_LOAD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (!init_done) begin
            lcd_rs   <= 1'b0;
            lcd_data <= w_rom;
            r_state  <= S_SETUP;
          end else begin
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            lcd_rs    <= cmd_rs;
            lcd_data  <= cmd_data;
            cmd_ready <= 1'b0;
            r_state   <= S_SETUP;
          end
        end

        S_SETUP: begin
          lcd_e        <= 1'b1;
          EnableCount  <= 1'b1;
          DisableCount <= 1'b1;
          r_cnt        <= '0;
          r_state      <= S_EHI;
        end

        S_EHI: begin
          if (TimerTick) begin
            if (w_done) begin
              lcd_e        <= 1'b0;
              DisableCount <= 1'b1;
              r_cnt        <= '0;
              r_state      <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (TimerTick) begin
            if (w_done) begin
              EnableCount <= 1'b0;
              if (!init_done && (r_idx != c_last_idx)) begin
                r_idx   <= r_idx + 1'b1;
                r_state <= S_LOAD;
              end else begin
                init_done <= 1'b1;
                cmd_ready <= 1'b1;
                r_state   <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        default: begin
          EnableCount <= 1'b0;
          r_state     <= S_PWR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lcd_cmd_sequencer
//  Purpose  : Directed self-checking bench for lcd_cmd_sequencer with scaled
//             timing (POWERUP=5, E_HIGH=1, CMD=3, CLEAR=7) and a timer model
//             ticking every 4 clocks while enabled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lcd_cmd_sequencer;

  logic       clock = 1'b0;
  logic       rst;
  logic       TimerTick;
  logic       EnableCount;
  logic       DisableCount;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit tick_en;
  int ph;

  logic [8:0] cap_q[$];
  int         wid_q[$];
  bit         mon_prev_e = 1'b0;
  int         mon_w = 0;

  lcd_cmd_sequencer #(
    .TICKS_POWERUP(5),
    .TICKS_E_HIGH (1),
    .TICKS_CMD    (3),
    .TICKS_CLEAR  (7),
    .CNT_W        (12)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .TimerTick   (TimerTick),
    .EnableCount (EnableCount),
    .DisableCount(DisableCount),
    .cmd_valid   (cmd_valid),
    .cmd_rs      (cmd_rs),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .init_done   (init_done),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_e       (lcd_e),
    .lcd_data    (lcd_data)
  );

  always #5 clock = ~clock;

  // Timer model: phase restarts on DisableCount, tick on every 4th clock.
  always @(negedge clock) begin
    if (!rst || !EnableCount) begin
      ph = 0;
      TimerTick = 1'b0;
    end else begin
      if (DisableCount) ph = 1;
      else ph = ph + 1;
      TimerTick = tick_en && (ph == 4);
      if (ph >= 4) ph = 0;
    end
  end

  // Record every E pulse: bus contents at the rising sample, width in clocks.
  always @(negedge clock) begin
    if (lcd_e && !mon_prev_e) begin
      cap_q.push_back({lcd_rs, lcd_data});
      mon_w = 0;
    end
    if (lcd_e) mon_w = mon_w + 1;
    if (!lcd_e && mon_prev_e) wid_q.push_back(mon_w);
    mon_prev_e = lcd_e;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {EnableCount, DisableCount, cmd_ready, init_done, lcd_rs, lcd_rw, lcd_e, lcd_data};
  endfunction

  task automatic hold_reset();
    @(negedge clock);
    rst = 1'b0;
    repeat (3) @(negedge clock);
    cap_q.delete();
    wid_q.delete();
    rst = 1'b1;
  endtask

  // Called on the negedge where reset was released. Expected schedule in
  // negedges after release: E rises at 23,41,59,77,95 (01 wait is 7 ticks)
  // and 129; the 06 wait ends with cmd_ready first seen at 145.
  task automatic run_init(input string tag);
    logic [7:0] exp_b[6];
    int cnt, first_e, dc_pre;
    logic idone_at_e;
    exp_b = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    cnt = 0; first_e = 0; dc_pre = 0; idone_at_e = 1'b1;
    @(negedge clock); cnt = 1;
    check_val({tag, " EnableCount after release"}, EnableCount, 1);
    check_val({tag, " DisableCount after release"}, DisableCount, 1);
    while (!cmd_ready && cnt < 3000) begin
      if (lcd_e && first_e == 0) begin
        first_e = cnt;
        idone_at_e = init_done;
      end
      if (!lcd_e && first_e == 0 && DisableCount) dc_pre++;
      @(negedge clock); cnt++;
    end
    check_val({tag, " first E rise clock"}, first_e, 23);
    check_val({tag, " DisableCount pulses before E"}, dc_pre, 1);
    check_val({tag, " init_done during init"}, idone_at_e, 0);
    check_val({tag, " clocks to cmd_ready"}, cnt, 145);
    check_val({tag, " init_done"}, init_done, 1);
    check_val({tag, " E pulse count"}, cap_q.size(), 6);
    for (int i = 0; i < 6 && i < cap_q.size(); i++)
      check_val($sformatf("%s byte %0d", tag, i), cap_q[i], {1'b0, exp_b[i]});
    for (int i = 0; i < wid_q.size(); i++)
      check_val($sformatf("%s E width %0d", tag, i), wid_q[i], 4);
    cap_q.delete();
    wid_q.delete();
  endtask

  task automatic run_cmd(input string tag, input logic rs, input logic [7:0] d, input int exp_wait);
    int n, w;
    logic prs;
    logic [7:0] pdat;
    n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge clock); n++; end
    check_val({tag, " ready before send"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_data = ~d; cmd_rs = ~rs;
    check_val({tag, " ready drops"}, cmd_ready, 0);
    n = 0; prs = lcd_rs; pdat = lcd_data;
    while (!lcd_e && n < 100) begin
      prs = lcd_rs; pdat = lcd_data;
      @(negedge clock); n++;
    end
    check_val({tag, " setup clocks"}, n, 1);
    check_val({tag, " rs at setup"}, prs, rs);
    check_val({tag, " data at setup"}, pdat, d);
    w = 0;
    while (lcd_e && w < 100) begin @(negedge clock); w++; end
    check_val({tag, " E width"}, w, 4);
    w = 0;
    while (!cmd_ready && w < 500) begin @(negedge clock); w++; end
    check_val({tag, " post-E wait"}, w, exp_wait);
    check_val({tag, " bus held"}, {lcd_rs, lcd_data}, {rs, d});
    cap_q.delete();
    wid_q.delete();
  endtask

  initial begin
    logic [8:0] strm[3];
    int n, bad;
    strm = '{9'h110, 9'h020, 9'h131};
    rst = 1'b0; tick_en = 1'b1; TimerTick = 1'b0;
    cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clock);
    check_val("reset outputs", all_outs(), 0);

    // Power-up and init sequence
    rst = 1'b1;
    run_init("init");

    // Single transfers: data, clear, data 01, home variants, non-clear 04
    run_cmd("data41", 1'b1, 8'h41, 12);
    run_cmd("clear01", 1'b0, 8'h01, 28);
    run_cmd("data01", 1'b1, 8'h01, 12);
    run_cmd("home03", 1'b0, 8'h03, 28);
    run_cmd("cmd04", 1'b0, 8'h04, 12);

    // cmd_valid held over three bytes, data changing only after handshake
    cap_q.delete(); wid_q.delete();
    @(negedge clock);
    cmd_valid = 1'b1; {cmd_rs, cmd_data} = strm[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!cmd_ready && n < 500) begin @(negedge clock); n++; end
      check_val($sformatf("stream ready %0d", k), cmd_ready, 1);
      @(negedge clock);
      if (k < 2) {cmd_rs, cmd_data} = strm[k+1];
      else cmd_valid = 1'b0;
    end
    n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clock); n++; end
    check_val("stream pulse count", cap_q.size(), 3);
    for (int i = 0; i < 3 && i < cap_q.size(); i++)
      check_val($sformatf("stream byte %0d", i), cap_q[i], strm[i]);

    // Reset during E high of init byte 4, then full replay
    hold_reset();
    repeat (78) @(negedge clock);
    check_val("byte4 E high", lcd_e, 1);
    check_val("byte4 data", lcd_data, 8'h0C);
    rst = 1'b0;
    #1;
    check_val("async reset outputs", all_outs(), 0);
    repeat (3) @(negedge clock);
    cap_q.delete(); wid_q.delete();
    rst = 1'b1;
    run_init("replay");

    // No ticks: stuck in power-up wait
    @(negedge clock);
    rst = 1'b0; tick_en = 1'b0;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    bad = 0;
    repeat (10000) begin
      @(negedge clock);
      if (lcd_e || cmd_ready) bad++;
    end
    check_val("no-tick E/ready activity", bad, 0);
    check_val("no-tick EnableCount", EnableCount, 1);
    check_val("no-tick DisableCount", DisableCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
